// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, line idle level and default frame constants
// used by both the transmitter and the receiver.
package uart_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StStart = 2'd1,
        StData  = 2'd2,
        StStop  = 2'd3
    } uart_state_e;

    localparam logic        UART_IDLE_LVL     = 1'b1;
    localparam int unsigned UART_CLKS_PER_BIT = 16;
    localparam int unsigned UART_DATA_BITS    = 8;

endpackage

// File: rtl/uart_bit_timer.sv
// Free-running per-bit down-counter; bit_end_o marks the last clock of each serial bit.
// restart_i realigns the bit boundary so that a full bit period starts on the next cycle.
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart_i,
    output logic bit_end_o
);

    localparam int unsigned   CntW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (restart_i || (cnt_q == '0)) begin
            cnt_d = CntMax;
        end else begin
            cnt_d = cnt_q - CntW'(1);
        end
    end

    assign bit_end_o = (cnt_q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter, LSB first, idle-high line, valid/ready input with a one-entry holding
// register so a byte offered mid-frame follows the current frame with no idle gap.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int unsigned DATA_BITS    = UART_DATA_BITS,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       txd,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int unsigned     IdxW     = $clog2(DATA_BITS + 1);
    localparam logic [IdxW-1:0] LastData = IdxW'(DATA_BITS - 1);
    localparam logic [IdxW-1:0] LastStop = IdxW'(STOP_BITS - 1);

    uart_state_e          state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] hold_q, hold_d;
    logic                 hold_full_q, hold_full_d;
    logic [IdxW-1:0]      idx_q, idx_d;
    logic                 txd_q, txd_d;
    logic                 hs, restart, bit_end, load_direct;

    // tx_ready depends only on a flop, so there is no path from tx_valid back to tx_ready.
    assign tx_ready = ~hold_full_q;
    assign hs       = tx_valid & ~hold_full_q;

    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .restart_i(restart),
        .bit_end_o(bit_end)
    );

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        idx_d       = idx_q;
        txd_d       = txd_q;
        restart     = 1'b0;
        load_direct = 1'b0;
        tx_done     = 1'b0;

        unique case (state_q)
            StIdle: begin
                txd_d = UART_IDLE_LVL;
                if (hs) begin
                    load_direct = 1'b1;
                end
            end
            StStart: begin
                if (bit_end) begin
                    state_d = StData;
                    idx_d   = '0;
                    txd_d   = shift_q[0];
                end
            end
            StData: begin
                if (bit_end) begin
                    if (idx_q == LastData) begin
                        state_d = StStop;
                        idx_d   = '0;
                        txd_d   = UART_IDLE_LVL;
                    end else begin
                        idx_d   = idx_q + IdxW'(1);
                        shift_d = shift_q >> 1;
                        txd_d   = shift_q[1];
                    end
                end
            end
            StStop: begin
                if (bit_end) begin
                    if (idx_q == LastStop) begin
                        tx_done = 1'b1;
                        if (hold_full_q) begin
                            shift_d     = hold_q;
                            hold_full_d = 1'b0;
                            state_d     = StStart;
                            txd_d       = ~UART_IDLE_LVL;
                        end else if (hs) begin
                            // Byte arriving as the frame ends starts immediately, no idle cycle.
                            load_direct = 1'b1;
                        end else begin
                            state_d = StIdle;
                        end
                    end else begin
                        idx_d = idx_q + IdxW'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (load_direct) begin
            shift_d = tx_data[DATA_BITS-1:0];
            state_d = StStart;
            txd_d   = ~UART_IDLE_LVL;
            restart = 1'b1;
        end else if (hs && (state_q != StIdle)) begin
            hold_d      = tx_data[DATA_BITS-1:0];
            hold_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            shift_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            idx_q       <= '0;
            txd_q       <= UART_IDLE_LVL;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            idx_q       <= idx_d;
            txd_q       <= txd_d;
        end
    end

    assign txd     = txd_q;
    assign tx_busy = (state_q != StIdle);

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: exact-cycle waveform checks against a frame model plus a
// behavioural mid-bit-sampling receiver for loopback and randomized byte streams.
module tb_uart_tx;

    localparam int CPB   = 16;
    localparam int FRAME = 10 * CPB;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       txd;
    logic       tx_busy;
    logic       tx_done;

    int n_checks = 0;
    int n_pass   = 0;

    uart_tx dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .tx_valid(tx_valid),
        .tx_data (tx_data),
        .tx_ready(tx_ready),
        .txd     (txd),
        .tx_busy (tx_busy),
        .tx_done (tx_done)
    );

    always #5 clk = ~clk;

    // Expected line level c cycles into an 8N1 frame carrying b.
    function automatic logic frame_level(input logic [7:0] b, input int c);
        int bit_n;
        bit_n = c / CPB;
        if (bit_n == 0) return 1'b0;
        if (bit_n <= 8) return b[bit_n-1];
        return 1'b1;
    endfunction

    // Reference receiver: detect start, sample each bit mid-period, record byte and stop level.
    logic [7:0] rx_q[$];
    logic       rx_stop_q[$];
    logic       rx_act = 1'b0;
    int         rx_cnt = 0;
    logic [7:0] rx_sh  = 8'h00;
    int         done_cnt = 0;

    always @(posedge clk) begin
        if (tx_done === 1'b1) done_cnt <= done_cnt + 1;
        if (rst_n !== 1'b1) begin
            rx_act <= 1'b0;
            rx_cnt <= 0;
        end else if (!rx_act) begin
            if (txd === 1'b0) begin
                rx_act <= 1'b1;
                rx_cnt <= 1;
            end
        end else begin
            rx_cnt <= rx_cnt + 1;
            if (rx_cnt % CPB == CPB / 2) begin
                if (rx_cnt / CPB == 0) begin
                    if (txd !== 1'b0) rx_act <= 1'b0;
                end else if (rx_cnt / CPB <= 8) begin
                    rx_sh <= {txd, rx_sh[7:1]};
                end else begin
                    rx_q.push_back(rx_sh);
                    rx_stop_q.push_back(txd);
                    rx_act <= 1'b0;
                end
            end
        end
    end

    // Offer one byte, holding tx_valid until accepted; call and return #1 after a rising edge.
    task automatic send_byte(input logic [7:0] b, output bit ok);
        ok       = 1'b0;
        tx_data  = b;
        tx_valid = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            if (tx_ready === 1'b1) begin
                @(posedge clk); #1;
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        tx_valid = 1'b0;
    endtask

    task automatic wait_rx(input int want);
        for (int i = 0; i < 5000 && (rx_q.size() < want || tx_busy !== 1'b0); i++) begin
            @(posedge clk); #1;
        end
        repeat (20) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bit ok;
        rst_n    = 1'b1;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({txd, tx_ready, tx_busy, tx_done} !== 4'b1100)
            $display("FAIL reset_init: txd/ready/busy/done=%b want 1100",
                     {txd, tx_ready, tx_busy, tx_done});
        else n_pass++;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        send_byte(8'hF0, ok);
        repeat (5) @(posedge clk);
        #1;
        n_checks++;
        if ({ok, tx_busy, txd} !== 3'b110)
            $display("FAIL reset_pre: ok/busy/txd=%b want 110", {ok, tx_busy, txd});
        else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({txd, tx_ready, tx_busy, tx_done} !== 4'b1100)
            $display("FAIL reset_async: txd/ready/busy/done=%b want 1100",
                     {txd, tx_ready, tx_busy, tx_done});
        else n_pass++;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        int   bad = 0, ndone = 0, done_at = -1;
        logic busy159 = 1'b0;
        tx_data  = 8'h55;
        tx_valid = 1'b1;
        @(posedge clk); #1;
        tx_valid = 1'b0;
        for (int c = 0; c < FRAME; c++) begin
            if (txd !== frame_level(8'h55, c)) bad++;
            if (tx_done === 1'b1) begin
                ndone++;
                done_at = c;
            end
            if (c == FRAME - 1) busy159 = tx_busy;
            @(posedge clk); #1;
        end
        n_checks++;
        if (bad != 0) $display("FAIL single_txd: %0d wrong cycles, want 0", bad);
        else n_pass++;
        n_checks++;
        if (ndone != 1) $display("FAIL single_done_cnt: got %0d want 1", ndone);
        else n_pass++;
        n_checks++;
        if (done_at != FRAME - 1) $display("FAIL single_done_cyc: got %0d want 159", done_at);
        else n_pass++;
        n_checks++;
        if (busy159 !== 1'b1) $display("FAIL single_busy159: got %b want 1", busy159);
        else n_pass++;
        n_checks++;
        if ({tx_busy, txd, tx_ready} !== 3'b011)
            $display("FAIL single_end: busy/txd/ready=%b want 011", {tx_busy, txd, tx_ready});
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int   bad = 0, ndone = 0, d0 = -1, d1 = -1, busy_bad = 0, rdy_bad = 0;
        logic exp_rdy;
        tx_data  = 8'hA5;
        tx_valid = 1'b1;
        @(posedge clk); #1;
        tx_valid = 1'b0;
        for (int c = 0; c < 2 * FRAME; c++) begin
            if (c == 20) begin
                tx_data  = 8'h3C;
                tx_valid = 1'b1;
            end
            if (c == 21) tx_valid = 1'b0;
            if (c < FRAME) begin
                if (txd !== frame_level(8'hA5, c)) bad++;
            end else begin
                if (txd !== frame_level(8'h3C, c - FRAME)) bad++;
            end
            if (tx_done === 1'b1) begin
                if (ndone == 0) d0 = c;
                else d1 = c;
                ndone++;
            end
            if (tx_busy !== 1'b1) busy_bad++;
            exp_rdy = !(c >= 21 && c < FRAME);
            if (tx_ready !== exp_rdy) rdy_bad++;
            @(posedge clk); #1;
        end
        n_checks++;
        if (bad != 0) $display("FAIL b2b_txd: %0d wrong cycles, want 0", bad);
        else n_pass++;
        n_checks++;
        if (ndone != 2) $display("FAIL b2b_done_cnt: got %0d want 2", ndone);
        else n_pass++;
        n_checks++;
        if (d0 != FRAME - 1 || d1 - d0 != FRAME)
            $display("FAIL b2b_done_cyc: got %0d,%0d want 159,319", d0, d1);
        else n_pass++;
        n_checks++;
        if (busy_bad != 0) $display("FAIL b2b_busy: %0d idle cycles, want 0", busy_bad);
        else n_pass++;
        n_checks++;
        if (rdy_bad != 0) $display("FAIL b2b_ready: %0d wrong cycles, want 0", rdy_bad);
        else n_pass++;
        n_checks++;
        if ({tx_busy, txd, tx_ready} !== 3'b011)
            $display("FAIL b2b_end: busy/txd/ready=%b want 011", {tx_busy, txd, tx_ready});
        else n_pass++;
    endtask

    task automatic test_three_held();
        logic [7:0] b[3];
        int         acc[3];
        int         k = 0;
        int         base = rx_q.size();
        int         dbase = done_cnt;
        for (int i = 0; i < 3; i++) b[i] = 8'($urandom);
        for (int i = 0; i < 3; i++) acc[i] = -1;
        tx_data  = b[0];
        tx_valid = 1'b1;
        for (int c = 0; c < 1000 && k < 3; c++) begin
            if (tx_ready === 1'b1) begin
                acc[k] = c;
                k++;
            end
            @(posedge clk); #1;
            if (k < 3) tx_data = b[k];
        end
        tx_valid = 1'b0;
        n_checks++;
        if (k != 3) $display("FAIL held_accept_cnt: got %0d want 3", k);
        else n_pass++;
        n_checks++;
        if (acc[1] - acc[0] != 1 || acc[2] - acc[0] != FRAME + 1)
            $display("FAIL held_accept_cyc: got %0d,%0d,%0d want 0,1,161", acc[0], acc[1], acc[2]);
        else n_pass++;
        wait_rx(base + 3);
        n_checks++;
        if (rx_q.size() != base + 3) $display("FAIL held_rx_cnt: got %0d want %0d",
                                              rx_q.size() - base, 3);
        else n_pass++;
        for (int i = 0; i < 3 && base + i < rx_q.size(); i++) begin
            n_checks++;
            if (rx_q[base+i] !== b[i])
                $display("FAIL held_rx_byte%0d: got %h want %h", i, rx_q[base+i], b[i]);
            else n_pass++;
        end
        n_checks++;
        if (done_cnt - dbase != 3) $display("FAIL held_done: got %0d want 3", done_cnt - dbase);
        else n_pass++;
    endtask

    task automatic test_loopback();
        logic [7:0] pat[4];
        int         base = rx_q.size();
        int         nok = 0;
        bit         ok;
        pat[0] = 8'h00; pat[1] = 8'hFF; pat[2] = 8'h5A; pat[3] = 8'h81;
        for (int i = 0; i < 4; i++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #0;
            send_byte(pat[i], ok);
            if (ok) nok++;
        end
        n_checks++;
        if (nok != 4) $display("FAIL loop_accept: got %0d want 4", nok);
        else n_pass++;
        wait_rx(base + 4);
        n_checks++;
        if (rx_q.size() != base + 4) $display("FAIL loop_rx_cnt: got %0d want 4",
                                              rx_q.size() - base);
        else n_pass++;
        for (int i = 0; i < 4 && base + i < rx_q.size(); i++) begin
            n_checks++;
            if (rx_q[base+i] !== pat[i] || rx_stop_q[base+i] !== 1'b1)
                $display("FAIL loop_rx%0d: got data %h status %b want %h status 1",
                         i, rx_q[base+i], rx_stop_q[base+i], pat[i]);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid_frame();
        int base = rx_q.size();
        int dbase = done_cnt;
        int bad = 0;
        bit ok0, ok1;
        send_byte(8'hC3, ok0);
        send_byte(8'h77, ok1);
        repeat (68) @(posedge clk);
        #1;
        // Frame cycle 69 sits in data bit 3, with 0x77 waiting in the holding register.
        n_checks++;
        if ({ok0, ok1, tx_ready, txd} !== {3'b110, frame_level(8'hC3, 69)})
            $display("FAIL rstmid_pre: ok/ok/ready/txd=%b want 110%b",
                     {ok0, ok1, tx_ready, txd}, frame_level(8'hC3, 69));
        else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({txd, tx_ready, tx_busy, tx_done} !== 4'b1100)
            $display("FAIL rstmid_async: txd/ready/busy/done=%b want 1100",
                     {txd, tx_ready, tx_busy, tx_done});
        else n_pass++;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        for (int c = 0; c < 200; c++) begin
            if (txd !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) bad++;
            @(posedge clk); #1;
        end
        n_checks++;
        if (bad != 0) $display("FAIL rstmid_quiet: %0d active cycles, want 0", bad);
        else n_pass++;
        n_checks++;
        if (rx_q.size() != base || done_cnt != dbase)
            $display("FAIL rstmid_discard: rx %0d done %0d, want 0 0",
                     rx_q.size() - base, done_cnt - dbase);
        else n_pass++;
        send_byte(8'h11, ok0);
        wait_rx(base + 1);
        n_checks++;
        if (rx_q.size() != base + 1 || rx_q[rx_q.size()-1] !== 8'h11)
            $display("FAIL rstmid_next: got %0d bytes last %h want 1 byte 11",
                     rx_q.size() - base, (rx_q.size() > 0) ? rx_q[rx_q.size()-1] : 8'hxx);
        else n_pass++;
    endtask

    task automatic test_random_stream();
        logic [7:0] sent[$];
        int         base = rx_q.size();
        int         dbase = done_cnt;
        int         nok = 0;
        bit         ok;
        logic [7:0] b;
        for (int i = 0; i < 12; i++) begin
            b = 8'($urandom);
            sent.push_back(b);
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, 30)) @(posedge clk);
                #1;
            end
            send_byte(b, ok);
            if (ok) nok++;
        end
        n_checks++;
        if (nok != 12) $display("FAIL rand_accept: got %0d want 12", nok);
        else n_pass++;
        wait_rx(base + 12);
        n_checks++;
        if (rx_q.size() != base + 12 || done_cnt - dbase != 12)
            $display("FAIL rand_cnt: rx %0d done %0d want 12 12",
                     rx_q.size() - base, done_cnt - dbase);
        else n_pass++;
        for (int i = 0; i < 12 && base + i < rx_q.size(); i++) begin
            n_checks++;
            if (rx_q[base+i] !== sent[i] || rx_stop_q[base+i] !== 1'b1)
                $display("FAIL rand_rx%0d: got %h stop %b want %h stop 1",
                         i, rx_q[base+i], rx_stop_q[base+i], sent[i]);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_three_held();
        test_loopback();
        test_reset_mid_frame();
        test_random_stream();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed",
                 n_pass, n_checks);
        $fatal(1);
    end

endmodule
